// File: rtl/idct_row_feeder.sv
// Row feeder for the 8-tap systolic IDCT row stage: gathers c0..c7 serially and
// issues them skewed, one lane per cycle. Define IDCT_FEED_DOUBLE_BUF_EN for ping-pong buffering.
module idct_row_feeder (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [15:0] coef_in,
  input  logic               coef_valid,
  output logic               coef_ready,
  input  logic [5:0]         cfg_shift,
  input  logic [5:0]         cfg_add,
  output logic signed [24:0] d_in_1,
  output logic signed [24:0] d_in_2,
  output logic signed [24:0] d_in_3,
  output logic signed [24:0] d_in_4,
  output logic signed [24:0] d_in_5,
  output logic signed [24:0] d_in_6,
  output logic signed [24:0] d_in_7,
  output logic signed [24:0] d_in_8,
  output logic [7:0]         lane_valid,
  output logic [5:0]         shift,
  output logic [5:0]         add,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, LOAD, ISSUE} state_t;

`ifdef IDCT_FEED_DOUBLE_BUF_EN
  localparam int NBUF = 2;
  logic       wr_sel_q, wr_sel_d;
  logic       iss_sel_q, iss_sel_d;
  logic [1:0] full_q, full_d;
`else
  localparam int NBUF = 1;
  logic wr_sel_q;
  logic iss_sel_d;
  assign wr_sel_q  = 1'b0;
  assign iss_sel_d = 1'b0;
`endif

  state_t             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [2:0]         iss_cnt_q, iss_cnt_d;
  logic signed [15:0] coef_q [NBUF][8];
  logic signed [15:0] coef_d [NBUF][8];
  logic [5:0]         row_shift_q [NBUF];
  logic [5:0]         row_shift_d [NBUF];
  logic [5:0]         row_add_q [NBUF];
  logic [5:0]         row_add_d [NBUF];
  logic [7:0]         lane_valid_q, lane_valid_d;
  logic signed [24:0] lane_q [8];
  logic signed [24:0] lane_d [8];
  logic [5:0]         shift_q, shift_d;
  logic [5:0]         add_q, add_d;
  logic               ready_q, ready_d;
  logic               accept, last, issue_done, start;

  always_comb begin
    accept     = coef_valid && ready_q;
    last       = accept && (cnt_q == 3'd7);
    issue_done = (state_q == ISSUE) && (iss_cnt_q == 3'd7);
    cnt_d      = accept ? cnt_q + 3'd1 : cnt_q;

    coef_d      = coef_q;
    row_shift_d = row_shift_q;
    row_add_d   = row_add_q;
    if (accept) begin
      coef_d[wr_sel_q][cnt_q] = coef_in;
      // Row parameters travel with c0 so a later cfg change cannot leak into this row.
      if (cnt_q == 3'd0) begin
        row_shift_d[wr_sel_q] = cfg_shift;
        row_add_d[wr_sel_q]   = cfg_add;
      end
    end

`ifdef IDCT_FEED_DOUBLE_BUF_EN
    start     = 1'b0;
    wr_sel_d  = wr_sel_q;
    iss_sel_d = iss_sel_q;
    full_d    = full_q;
    if (issue_done) full_d[iss_sel_q] = 1'b0;
    if (last) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = ~wr_sel_q;
    end
    // A pending row launches right behind the current one for gapless issue.
    if (issue_done && full_q[~iss_sel_q]) begin
      start     = 1'b1;
      iss_sel_d = ~iss_sel_q;
    end else if (last && ((state_q != ISSUE) || issue_done)) begin
      start     = 1'b1;
      iss_sel_d = wr_sel_q;
    end
`else
    start = last;
`endif

    if (start)                 iss_cnt_d = 3'd0;
    else if (state_q == ISSUE) iss_cnt_d = iss_cnt_q + 3'd1;
    else                       iss_cnt_d = 3'd0;

    if (start || ((state_q == ISSUE) && !issue_done)) state_d = ISSUE;
    else if (cnt_d != 3'd0)                           state_d = LOAD;
    else                                              state_d = IDLE;

`ifdef IDCT_FEED_DOUBLE_BUF_EN
    ready_d = ~(full_d[0] & full_d[1]);
`else
    ready_d = (state_d != ISSUE);
`endif

    // Skew: lane k fires k-1 cycles after lane 1; idle lanes carry zero into the adder chain.
    lane_valid_d = {lane_valid_q[6:0], start};
    for (int k = 0; k < 8; k++) begin
      lane_d[k] = '0;
      if (lane_valid_d[k])
        lane_d[k] = {{9{coef_q[iss_sel_d][k][15]}}, coef_q[iss_sel_d][k]};
    end

    shift_d = shift_q;
    add_d   = add_q;
    if (lane_valid_d[7]) begin
      shift_d = row_shift_q[iss_sel_d];
      add_d   = row_add_q[iss_sel_d];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      iss_cnt_q    <= '0;
      lane_valid_q <= '0;
      shift_q      <= '0;
      add_q        <= '0;
      ready_q      <= 1'b0;
      for (int b = 0; b < NBUF; b++) begin
        row_shift_q[b] <= '0;
        row_add_q[b]   <= '0;
        for (int k = 0; k < 8; k++) coef_q[b][k] <= '0;
      end
      for (int k = 0; k < 8; k++) lane_q[k] <= '0;
`ifdef IDCT_FEED_DOUBLE_BUF_EN
      wr_sel_q  <= 1'b0;
      iss_sel_q <= 1'b0;
      full_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      iss_cnt_q    <= iss_cnt_d;
      lane_valid_q <= lane_valid_d;
      shift_q      <= shift_d;
      add_q        <= add_d;
      ready_q      <= ready_d;
      coef_q       <= coef_d;
      row_shift_q  <= row_shift_d;
      row_add_q    <= row_add_d;
      lane_q       <= lane_d;
`ifdef IDCT_FEED_DOUBLE_BUF_EN
      wr_sel_q  <= wr_sel_d;
      iss_sel_q <= iss_sel_d;
      full_q    <= full_d;
`endif
    end
  end

  assign coef_ready = ready_q;
  assign lane_valid = lane_valid_q;
  assign shift      = shift_q;
  assign add        = add_q;
  assign busy       = (state_q != IDLE) || (|lane_valid_q);
  assign d_in_1     = lane_q[0];
  assign d_in_2     = lane_q[1];
  assign d_in_3     = lane_q[2];
  assign d_in_4     = lane_q[3];
  assign d_in_5     = lane_q[4];
  assign d_in_6     = lane_q[5];
  assign d_in_7     = lane_q[6];
  assign d_in_8     = lane_q[7];

endmodule

// File: tb/tb_idct_row_feeder.sv
// Directed self-checking bench for idct_row_feeder: skewed lane issue, sign extension,
// row parameter binding, load stalls and reset abort; back-to-back rows in the double-buffer build.
module tb_idct_row_feeder;

  logic               clk;
  logic               reset;
  logic signed [15:0] coef_in;
  logic               coef_valid;
  logic               coef_ready;
  logic [5:0]         cfg_shift;
  logic [5:0]         cfg_add;
  logic signed [24:0] d_in_1, d_in_2, d_in_3, d_in_4, d_in_5, d_in_6, d_in_7, d_in_8;
  logic [7:0]         lane_valid;
  logic [5:0]         shift;
  logic [5:0]         add;
  logic               busy;

  logic [24:0]        d_arr [8];
  logic signed [15:0] row_a [8];
  logic signed [15:0] row_b [8];
  logic signed [15:0] row_c [8];
  int                 checks;
  int                 errors;

`ifdef IDCT_FEED_DOUBLE_BUF_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  idct_row_feeder dut (
    .clk        (clk),
    .reset      (reset),
    .coef_in    (coef_in),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .cfg_shift  (cfg_shift),
    .cfg_add    (cfg_add),
    .d_in_1     (d_in_1),
    .d_in_2     (d_in_2),
    .d_in_3     (d_in_3),
    .d_in_4     (d_in_4),
    .d_in_5     (d_in_5),
    .d_in_6     (d_in_6),
    .d_in_7     (d_in_7),
    .d_in_8     (d_in_8),
    .lane_valid (lane_valid),
    .shift      (shift),
    .add        (add),
    .busy       (busy)
  );

  assign d_arr[0] = d_in_1;
  assign d_arr[1] = d_in_2;
  assign d_arr[2] = d_in_3;
  assign d_arr[3] = d_in_4;
  assign d_arr[4] = d_in_5;
  assign d_arr[5] = d_in_6;
  assign d_arr[6] = d_in_7;
  assign d_arr[7] = d_in_8;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [24:0] ext16(input logic [15:0] v);
    return {{9{v[15]}}, v};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Feeds one row; a set bit in stall_mask inserts one idle cycle before that coefficient.
  // Returns in cycle T+1 where T is the cycle c7 was accepted.
  task automatic applyStimulus(input logic signed [15:0] row [8], input logic [7:0] stall_mask,
                               input logic [5:0] sh, input logic [5:0] ad);
    int w;
    for (int i = 0; i < 8; i++) begin
      if (stall_mask[i]) begin
        coef_valid = 1'b0;
        coef_in    = 16'h5555;
        step();
      end
      coef_in    = row[i];
      coef_valid = 1'b1;
      cfg_shift  = (i == 0) ? sh : 6'h15;
      cfg_add    = (i == 0) ? ad : 6'h2a;
      w = 0;
      while (!coef_ready && w < 40) begin
        step();
        w++;
      end
      if (w >= 40) checkOutput("ready_timeout", 32'd0, 32'd1);
      step();
    end
    coef_valid = 1'b0;
    coef_in    = 16'h0;
  endtask

  task automatic checkRow(input logic signed [15:0] row [8], input logic [5:0] sh, input logic [5:0] ad,
                          input logic [5:0] psh, input logic [5:0] pad);
    for (int k = 1; k <= 8; k++) begin
      checkOutput($sformatf("lane_valid@T+%0d", k), {24'd0, lane_valid}, 32'(8'd1 << (k - 1)));
      for (int j = 0; j < 8; j++)
        checkOutput($sformatf("d_in_%0d@T+%0d", j + 1, k), {7'd0, d_arr[j]},
                    {7'd0, (j == k - 1) ? ext16(row[j]) : 25'd0});
      checkOutput($sformatf("shift@T+%0d", k), {26'd0, shift}, {26'd0, (k == 8) ? sh : psh});
      checkOutput($sformatf("add@T+%0d", k), {26'd0, add}, {26'd0, (k == 8) ? ad : pad});
      checkOutput($sformatf("ready@T+%0d", k), {31'd0, coef_ready}, {31'd0, DBL});
      checkOutput($sformatf("busy@T+%0d", k), {31'd0, busy}, 32'd1);
      step();
    end
    checkOutput("ready@T+9", {31'd0, coef_ready}, 32'd1);
    checkOutput("lane_valid@T+9", {24'd0, lane_valid}, 32'd0);
    checkOutput("busy@T+9", {31'd0, busy}, 32'd0);
    checkOutput("shift_hold@T+9", {26'd0, shift}, {26'd0, sh});
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    coef_valid = 1'b0;
    coef_in    = 16'h0;
    cfg_shift  = 6'd0;
    cfg_add    = 6'd0;
    row_a = '{16'sd1, -16'sd2, 16'sd3, -16'sd4, 16'sd5, -16'sd6, 16'sd7, -16'sd8};
    row_b = '{16'sd100, -16'sd300, 16'sh7fff, 16'sh8000, 16'sd0, -16'sd1, 16'sd1234, -16'sd999};
    row_c = '{16'sd11, 16'sd22, 16'sd33, 16'sd44, 16'sd55, 16'sd66, 16'sd77, 16'sd88};

    repeat (3) step();
    checkOutput("rst_ready", {31'd0, coef_ready}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_lane_valid", {24'd0, lane_valid}, 32'd0);
    checkOutput("rst_shift", {26'd0, shift}, 32'd0);
    checkOutput("rst_add", {26'd0, add}, 32'd0);
    for (int j = 0; j < 8; j++)
      checkOutput($sformatf("rst_d_in_%0d", j + 1), {7'd0, d_arr[j]}, 32'd0);
    reset = 1'b0;
    step();
    checkOutput("ready_after_rst", {31'd0, coef_ready}, 32'd1);

    $display("[TB] row A: basic skew, shift/add 7/63");
    applyStimulus(row_a, 8'h00, 6'd7, 6'd63);
    checkRow(row_a, 6'd7, 6'd63, 6'd0, 6'd0);

    $display("[TB] row B: extremes incl. 0x8000 in slot 3, shift/add 12/32");
    applyStimulus(row_b, 8'h00, 6'd12, 6'd32);
    checkRow(row_b, 6'd12, 6'd32, 6'd7, 6'd63);

    $display("[TB] row A again with load stalls");
    applyStimulus(row_a, 8'b0000_1010, 6'd5, 6'd9);
    checkRow(row_a, 6'd5, 6'd9, 6'd12, 6'd32);

    $display("[TB] reset during issue");
    applyStimulus(row_c, 8'h00, 6'd3, 6'd4);
    step();
    step();
    checkOutput("abort_lane3@T+3", {24'd0, lane_valid}, 32'h04);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int c = 4; c <= 10; c++) begin
      checkOutput($sformatf("abort_lane_valid@T+%0d", c), {24'd0, lane_valid}, 32'd0);
      for (int j = 0; j < 8; j++)
        checkOutput($sformatf("abort_d_in_%0d@T+%0d", j + 1, c), {7'd0, d_arr[j]}, 32'd0);
      checkOutput($sformatf("abort_shift@T+%0d", c), {26'd0, shift}, 32'd0);
      checkOutput($sformatf("abort_add@T+%0d", c), {26'd0, add}, 32'd0);
      checkOutput($sformatf("abort_ready@T+%0d", c), {31'd0, coef_ready}, (c == 4) ? 32'd0 : 32'd1);
      step();
    end
    applyStimulus(row_c, 8'h00, 6'd33, 6'd17);
    checkRow(row_c, 6'd33, 6'd17, 6'd0, 6'd0);

`ifdef IDCT_FEED_DOUBLE_BUF_EN
    $display("[TB] three rows back-to-back");
    cfg_shift = 6'd1;
    cfg_add   = 6'd2;
    for (int n = 0; n < 31; n++) begin
      coef_valid = (n < 24);
      coef_in    = 16'(n * 1000 - 7000);
      step();
      if (n + 1 <= 24)
        checkOutput($sformatf("b2b_ready@%0d", n + 1), {31'd0, coef_ready}, 32'd1);
      if (n + 1 < 8) begin
        checkOutput($sformatf("b2b_lane_valid@%0d", n + 1), {24'd0, lane_valid}, 32'd0);
      end else begin
        checkOutput($sformatf("b2b_lane_valid@%0d", n + 1), {24'd0, lane_valid},
                    32'(8'd1 << ((n - 7) % 8)));
        checkOutput($sformatf("b2b_data@%0d", n + 1), {7'd0, d_arr[(n - 7) % 8]},
                    {7'd0, ext16(16'((n - 7) * 1000 - 7000))});
      end
    end
    coef_valid = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
